button_event: RTL and testbench

//  Converts one debounced button level into single-cycle user events for the clock's

---
 rtl/button_event_if.sv | 21 ++
 rtl/button_event.sv | 117 +++++++++++
 tb/tb_button_event.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/button_event_if.sv
// Signal bundle between the button debouncer side and the event generator.
// master drives enable and button level; slave produces the event pulses.
interface button_event_if;
    logic en;
    logic clean_btn;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    modport master (
        output en, clean_btn,
        input  press_pulse, release_pulse, long_pulse, repeat_pulse, held
    );

    modport slave (
        input  en, clean_btn,
        output press_pulse, release_pulse, long_pulse, repeat_pulse, held
    );
endinterface

// File: rtl/button_event.sv
// Turns a debounced button level into single-cycle press/release/long/repeat events
// plus a registered held level for the time-set controller.
module button_event #(
    parameter int unsigned LONG_CYCLES   = 100_000_000,
    parameter int unsigned REPEAT_CYCLES = 20_000_000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic          clk,
    input  logic          rst,
    button_event_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        REPEAT
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic             btn_q;
    logic             rise;

    logic press_nx, release_nx, long_nx, repeat_nx, held_nx;
    logic press_r, release_r, long_r, repeat_r, held_r;

    assign rise = bus.clean_btn & ~btn_q;

    always_comb begin
        state_nx   = state;
        count_nx   = count;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        long_nx    = 1'b0;
        repeat_nx  = 1'b0;

        // Disable overrides everything, including a pending release.
        if (!bus.en) begin
            state_nx = IDLE;
            count_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_nx = PRESSED;
                        count_nx = '0;
                        press_nx = 1'b1;
                    end
                end
                PRESSED: begin
                    if (!bus.clean_btn) begin
                        state_nx   = IDLE;
                        count_nx   = '0;
                        release_nx = 1'b1;
                    end else if (count == LONG_LAST) begin
                        state_nx  = REPEAT;
                        count_nx  = '0;
                        long_nx   = 1'b1;
                        repeat_nx = 1'b1;
                    end else begin
                        count_nx = count + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!bus.clean_btn) begin
                        state_nx   = IDLE;
                        count_nx   = '0;
                        release_nx = 1'b1;
                    end else if (count == REPEAT_LAST) begin
                        count_nx  = '0;
                        repeat_nx = 1'b1;
                    end else begin
                        count_nx = count + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    count_nx = '0;
                end
            endcase
        end

        held_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            btn_q     <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            long_r    <= 1'b0;
            repeat_r  <= 1'b0;
            held_r    <= 1'b0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            btn_q     <= bus.clean_btn;
            press_r   <= press_nx;
            release_r <= release_nx;
            long_r    <= long_nx;
            repeat_r  <= repeat_nx;
            held_r    <= held_nx;
        end
    end

    assign bus.press_pulse   = press_r;
    assign bus.release_pulse = release_r;
    assign bus.long_pulse    = long_r;
    assign bus.repeat_pulse  = repeat_r;
    assign bus.held          = held_r;

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: a hold-age reference model queues the expected
// output vector per clock; an independent monitor pops and compares after each edge.
module tb_button_event;

    localparam int L = 10;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    button_event_if bus ();

    button_event #(
        .LONG_CYCLES  (L),
        .REPEAT_CYCLES(R),
        .CNT_W        (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Expected vector order: {held, press, release, long, repeat}
    logic [4:0] exp_q[$];

    // Reference model: tracks whether a press is live and how many edges since it began.
    bit m_track = 0;
    int m_age   = 0;
    bit m_prev  = 0;

    function automatic logic [4:0] model_step(input bit e, input bit b);
        logic [4:0] v;
        v = '0;
        if (!e) begin
            m_track = 0;
        end else if (m_track) begin
            m_age++;
            if (!b) begin
                v[2]    = 1'b1;
                m_track = 0;
            end else if (m_age == L) begin
                v[1] = 1'b1;
                v[0] = 1'b1;
            end else if (m_age > L && ((m_age - L) % R) == 0) begin
                v[0] = 1'b1;
            end
        end else if (b && !m_prev) begin
            m_track = 1;
            m_age   = 0;
            v[3]    = 1'b1;
        end
        m_prev = b;
        v[4]   = m_track;
        return v;
    endfunction

    function automatic logic [4:0] dut_vec();
        return {bus.held, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse};
    endfunction

    task automatic cyc(input bit e, input bit b);
        @(negedge clk);
        bus.en        = e;
        bus.clean_btn = b;
        exp_q.push_back(model_step(e, b));
    endtask

    task automatic check_now(input string name, input logic [4:0] want);
        logic [4:0] got;
        got = dut_vec();
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %b required %b", name, got, want);
        end
    endtask

    // Monitor: outputs are presented every cycle, so each edge consumes one expectation.
    int mon_cyc = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon_cyc++;
            if (exp_q.size() > 0) begin
                logic [4:0] want;
                logic [4:0] got;
                want = exp_q.pop_front();
                got  = dut_vec();
                compared++;
                if (got !== want) begin
                    mismatched++;
                    $display("FAIL outputs cycle %0d t=%0t: got %b required %b (held,press,rel,long,rep)",
                             mon_cyc, $time, got, want);
                end
            end
        end
    end

    initial begin
        bus.en        = 1'b1;
        bus.clean_btn = 1'b0;
        #12;
        check_now("reset_state", 5'b0);
        @(negedge clk);
        rst = 1'b0;

        cyc(1, 0); cyc(1, 0);

        // 1: short press
        repeat (5) cyc(1, 1);
        repeat (3) cyc(1, 0);

        // 2: 30-clock hold with auto-repeat
        repeat (30) cyc(1, 1);
        repeat (3) cyc(1, 0);

        // 3: release exactly on the long threshold
        repeat (10) cyc(1, 1);
        repeat (3) cyc(1, 0);

        // 4: asynchronous reset mid-hold, button still held afterwards
        repeat (12) cyc(1, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_now("async_reset_clear", 5'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        m_track = 0;
        m_prev  = 0;
        repeat (4) cyc(1, 1);
        repeat (2) cyc(1, 0);

        // 5: enable dropped during hold, restored with button still high
        repeat (5) cyc(1, 1);
        repeat (3) cyc(0, 1);
        repeat (3) cyc(1, 1);
        cyc(1, 0);
        repeat (3) cyc(1, 1);
        repeat (2) cyc(1, 0);

        // 6: back-to-back presses
        repeat (3) cyc(1, 1);
        cyc(1, 0);
        repeat (3) cyc(1, 1);
        repeat (2) cyc(1, 0);

        // Randomized: long runs of a level, occasional enable drops
        begin
            bit b = 0;
            bit e = 1;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 11) == 0) b = ~b;
                e = ($urandom_range(0, 39) != 0);
                cyc(e, b);
            end
        end
        repeat (2) cyc(1, 0);

        // Drain with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
